// File: rtl/modport_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : modport_counter_bank
// Brief    : Single-port bank of 2**ADDR_W event counters. Each enabled cycle
//            either increments the addressed counter or registers its value
//            onto the data output.
// Revision : 1.0 - initial release
// ============================================================================
module modport_counter_bank #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              read,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_counters [c_DEPTH];
    logic [DATA_W-1:0] r_data;

    // Counters wrap modulo 2**DATA_W; a read returns the pre-edge value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_counters[i] <= '0;
            end
            r_data <= '0;
        end else if (enable) begin
            if (read) begin
                r_data <= r_counters[addr];
            end else begin
                r_counters[addr] <= r_counters[addr] + DATA_W'(1);
            end
        end
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_modport_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_modport_counter_bank
// Brief    : Directed self-checking bench for modport_counter_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modport_counter_bank;

    logic       clock;
    logic       reset_n;
    logic       read;
    logic       enable;
    logic [7:0] addr;
    logic [7:0] data;

    int tests;
    int fails;

    modport_counter_bank #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .read    (read),
        .enable  (enable),
        .addr    (addr),
        .data    (data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, return 1 ns after the capturing rising edge.
    task automatic op(input logic en, input logic rd, input logic [7:0] a);
        @(negedge clock);
        enable = en;
        read   = rd;
        addr   = a;
        @(posedge clock);
        #1;
    endtask

    task automatic inc(input logic [7:0] a, input int n);
        for (int k = 0; k < n; k++) op(1'b1, 1'b0, a);
    endtask

    task automatic rd(input logic [7:0] a);
        op(1'b1, 1'b1, a);
    endtask

    task automatic idle_x();
        @(negedge clock);
        enable = 1'b0;
        read   = 1'bx;
        addr   = 'x;
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        enable  = 1'b1;
        read    = 1'b0;
        addr    = 8'h00;

        // Reset held with traffic present
        repeat (2) @(posedge clock);
        #1;
        check("reset_data", data, 8'd0);
        @(negedge clock);
        enable  = 1'b0;
        reset_n = 1'b1;

        rd(8'h00); check("post_reset_rd_00", data, 8'd0);
        rd(8'h7F); check("post_reset_rd_7f", data, 8'd0);
        rd(8'hFF); check("post_reset_rd_ff", data, 8'd0);

        // Increment then read
        inc(8'h10, 3);
        check("data_holds_on_inc", data, 8'd0);
        rd(8'h10); check("rd_10_after_3", data, 8'd3);
        rd(8'h11); check("rd_11_untouched", data, 8'd0);

        // Wrap
        inc(8'h55, 256);
        rd(8'h55); check("wrap_256", data, 8'd0);
        inc(8'h55, 1);
        rd(8'h55); check("wrap_257", data, 8'd1);

        // Back-to-back increment then read, followed by X-idle cycles
        rd(8'h10); check("rd_10_prewrap_ok", data, 8'd3);
        inc(8'h20, 1);
        rd(8'h20); check("b2b_rd_20", data, 8'd1);
        for (int k = 0; k < 3; k++) begin
            idle_x();
            check("idle_hold", data, 8'd1);
        end
        rd(8'h10); check("idle_no_change_10", data, 8'd3);
        rd(8'h20); check("idle_no_change_20", data, 8'd1);

        // Interleaved addresses
        inc(8'h00, 1); inc(8'hFF, 1);
        inc(8'h00, 1); inc(8'hFF, 1);
        inc(8'hFF, 3);
        rd(8'hFF); check("interleave_ff", data, 8'd5);
        rd(8'h00); check("interleave_00", data, 8'd2);

        // Mid-operation asynchronous reset
        inc(8'h30, 4);
        rd(8'h30); check("rd_30_before_reset", data, 8'd4);
        @(negedge clock);
        enable = 1'b1;
        read   = 1'b0;
        addr   = 8'h30;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_data", data, 8'd0);
        enable = 1'b0;
        #1;
        reset_n = 1'b1;
        rd(8'h30); check("rd_30_after_reset", data, 8'd0);
        rd(8'h10); check("rd_10_after_reset", data, 8'd0);
        rd(8'h55); check("rd_55_after_reset", data, 8'd0);
        inc(8'h30, 1);
        rd(8'h30); check("first_inc_after_reset", data, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
